// File: rtl/tx_sample_scheduler_if.sv
// Sample-stream, auxiliary-requester and serializer-word signals of tx_sample_scheduler.
// The slave modport is the scheduler side; the master modport is the surrounding logic.
interface tx_sample_scheduler_if;
  logic        s_valid;
  logic        s_ready;
  logic [13:0] s_idata;
  logic [13:0] s_qdata;
  logic        tp_req;
  logic [13:0] tp_idata;
  logic [13:0] tp_qdata;
  logic        tp_gnt;
  logic        ser_oe;
  logic [13:0] ser_idata;
  logic [13:0] ser_qdata;
  logic        ser_data_ready;

  modport slave (
    input  s_valid, s_idata, s_qdata, tp_req, tp_idata, tp_qdata, ser_data_ready,
    output s_ready, tp_gnt, ser_oe, ser_idata, ser_qdata
  );

  modport master (
    output s_valid, s_idata, s_qdata, tp_req, tp_idata, tp_qdata, ser_data_ready,
    input  s_ready, tp_gnt, ser_oe, ser_idata, ser_qdata
  );
endinterface

// File: rtl/tx_sample_scheduler.sv
// Primes a sample FIFO, then fills serializer word slots from it or from the aux requester.
// Optional macro TX_SCHED_UNDERFLOW_CNT_EN builds the 16-bit saturating underflow counter.
module tx_sample_scheduler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  tx_sample_scheduler_if.slave          bus,
  input  logic                          enable,
  input  logic                          underflow_clr,
  output logic                          underflow,
  output logic [15:0]                   underflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          r_state, w_next_state;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [27:0]     r_mem [FIFO_DEPTH];
  logic            r_aux_last;
  logic            r_tp_gnt;
  logic            r_underflow;
  logic [13:0]     r_ser_idata, r_ser_qdata;

  logic w_ser_oe, w_s_ready, w_flush;
  logic w_full, w_empty, w_push, w_pop;
  logic w_run_slot, w_drain_slot, w_sel_aux, w_uflow;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_ser_oe     = 1'b0;
    w_s_ready    = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_flush = 1'b1;
        if (enable) w_next_state = ST_PRIME;
      end
      ST_PRIME: begin
        w_s_ready = !w_full;
        if (!enable) begin
          w_next_state = ST_IDLE;
          w_flush      = 1'b1;
        end else if (r_level >= LW'(PRIME_LEVEL)) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ser_oe  = 1'b1;
        w_s_ready = !w_full;
        if (!enable) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_ser_oe = 1'b1;
        if (enable)                             w_next_state = ST_RUN;
        else if (bus.ser_data_ready && w_empty) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Aux wins a slot unless it also took the previous one; an empty FIFO lets it win again.
  assign w_run_slot   = bus.ser_data_ready && (r_state == ST_RUN);
  assign w_drain_slot = bus.ser_data_ready && (r_state == ST_DRAIN);
  assign w_sel_aux    = w_run_slot && bus.tp_req && (!r_aux_last || w_empty);
  assign w_pop        = ((w_run_slot && !w_sel_aux) || w_drain_slot) && !w_empty;
  assign w_uflow      = w_run_slot && !w_sel_aux && w_empty;
  assign w_push       = bus.s_valid && w_s_ready;

  always_ff @(posedge clk) begin
    if (!reset_n || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // NOTE: the sample storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.s_idata, bus.s_qdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ser_idata <= '0;
      r_ser_qdata <= '0;
      r_tp_gnt    <= 1'b0;
      r_aux_last  <= 1'b0;
    end else begin
      r_tp_gnt <= w_sel_aux;
      if (r_state == ST_IDLE)              r_aux_last <= 1'b0;
      else if (w_run_slot || w_drain_slot) r_aux_last <= w_sel_aux;
      if (w_sel_aux) begin
        r_ser_idata <= bus.tp_idata;
        r_ser_qdata <= bus.tp_qdata;
      end else if (w_pop) begin
        {r_ser_idata, r_ser_qdata} <= r_mem[r_rd_ptr];
      end else if (w_uflow || w_drain_slot) begin
        r_ser_idata <= '0;
        r_ser_qdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || underflow_clr) r_underflow <= 1'b0;
    else if (w_uflow)              r_underflow <= 1'b1;
  end

`ifdef TX_SCHED_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_count;

  always_ff @(posedge clk) begin
    if (!reset_n || underflow_clr)           r_uf_count <= '0;
    else if (w_uflow && r_uf_count != 16'hFFFF) r_uf_count <= r_uf_count + 16'd1;
  end

  assign underflow_count = r_uf_count;
`else
  assign underflow_count = 16'h0;
`endif

  assign bus.s_ready   = w_s_ready;
  assign bus.ser_oe    = w_ser_oe;
  assign bus.tp_gnt    = r_tp_gnt;
  assign bus.ser_idata = r_ser_idata;
  assign bus.ser_qdata = r_ser_qdata;
  assign underflow     = r_underflow;
  assign fifo_level    = r_level;
  assign state         = r_state;

endmodule

// File: tb/tb_tx_sample_scheduler.sv
// Directed bench for tx_sample_scheduler: stimulus queues expected slot words,
// a monitor compares them after every slot strobe.
module tb_tx_sample_scheduler;

  localparam int FIFO_DEPTH  = 8;
  localparam int PRIME_LEVEL = 4;

`ifdef TX_SCHED_UNDERFLOW_CNT_EN
  localparam logic [15:0] EXP_UF3 = 16'd3;
`else
  localparam logic [15:0] EXP_UF3 = 16'd0;
`endif

  localparam logic [13:0] TP_I = 14'h2AA;
  localparam logic [13:0] TP_Q = 14'h155;

  typedef struct packed {
    logic [13:0] i;
    logic [13:0] q;
    logic        gnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        underflow_clr;
  logic        underflow;
  logic [15:0] underflow_count;
  logic [3:0]  fifo_level;
  logic [1:0]  state;

  tx_sample_scheduler_if bus();

  tx_sample_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .enable          (enable),
    .underflow_clr   (underflow_clr),
    .underflow       (underflow),
    .underflow_count (underflow_count),
    .fifo_level      (fifo_level),
    .state           (state)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic slot_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] qv(input logic [13:0] i);
    return i ^ 14'h3FFF;
  endfunction

  // Monitor: a slot strobe at a posedge yields a word to compare at the following negedge.
  always @(posedge clk) slot_seen <= bus.ser_data_ready;

  always @(negedge clk) begin
    if (slot_seen) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_slot", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ser_idata", bus.ser_idata, e.i);
        check("ser_qdata", bus.ser_qdata, e.q);
        check("tp_gnt",    bus.tp_gnt,    e.gnt);
      end
    end else begin
      check("tp_gnt_idle", bus.tp_gnt, 0);
    end
  end

  task automatic push(input logic [13:0] i);
    bus.s_valid = 1'b1;
    bus.s_idata = i;
    bus.s_qdata = qv(i);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // One-cycle slot strobe (optionally with a clear or a concurrent push), then an idle cycle.
  task automatic slot(input logic [13:0] ei, input logic [13:0] eq, input logic eg,
                      input logic clr, input logic do_push, input logic [13:0] pi);
    exp_t e;
    e.i = ei; e.q = eq; e.gnt = eg;
    sb.push_back(e);
    bus.ser_data_ready = 1'b1;
    underflow_clr      = clr;
    bus.s_valid        = do_push;
    bus.s_idata        = pi;
    bus.s_qdata        = qv(pi);
    @(negedge clk);
    bus.ser_data_ready = 1'b0;
    underflow_clr      = 1'b0;
    bus.s_valid        = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     state, 0);
    check({tag, "_ser_oe"},    bus.ser_oe, 0);
    check({tag, "_s_ready"},   bus.s_ready, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_uf_count"},  underflow_count, 0);
    check({tag, "_level"},     fifo_level, 0);
    check({tag, "_idata"},     bus.ser_idata, 0);
    check({tag, "_qdata"},     bus.ser_qdata, 0);
  endtask

  initial begin
    reset_n            = 1'b0;
    enable             = 1'b0;
    underflow_clr      = 1'b0;
    bus.s_valid        = 1'b0;
    bus.s_idata        = '0;
    bus.s_qdata        = '0;
    bus.tp_req         = 1'b0;
    bus.tp_idata       = TP_I;
    bus.tp_qdata       = TP_Q;
    bus.ser_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");

    // Priming: level 4 reached, RUN one edge later, then the first three samples in order.
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    check("prime_state", state, 1);
    check("prime_s_ready", bus.s_ready, 1);
    check("prime_ser_oe", bus.ser_oe, 0);
    for (int k = 1; k <= 4; k++) push(14'(k));
    check("prime_level4", fifo_level, 4);
    check("prime_still_prime", state, 1);
    @(negedge clk);
    check("run_state", state, 2);
    check("run_ser_oe", bus.ser_oe, 1);
    for (int k = 1; k <= 3; k++) slot(14'(k), qv(14'(k)), 1'b0, 1'b0, 1'b0, '0);
    check("after_prime_level", fifo_level, 1);

    // Arbitration: 5 samples queued, aux held high over 4 slots -> aux, FIFO, aux, FIFO.
    for (int k = 5; k <= 8; k++) push(14'(k));
    check("arb_level5", fifo_level, 5);
    bus.tp_req = 1'b1;
    slot(TP_I, TP_Q, 1'b1, 1'b0, 1'b0, '0);
    slot(14'd4, qv(14'd4), 1'b0, 1'b0, 1'b0, '0);
    slot(TP_I, TP_Q, 1'b1, 1'b0, 1'b0, '0);
    slot(14'd5, qv(14'd5), 1'b0, 1'b0, 1'b0, '0);
    bus.tp_req = 1'b0;
    check("arb_level3", fifo_level, 3);

    // Underflow: empty the FIFO, three empty slots, then a clear colliding with a fourth.
    for (int k = 6; k <= 8; k++) slot(14'(k), qv(14'(k)), 1'b0, 1'b0, 1'b0, '0);
    check("uf_pre_flag", underflow, 0);
    for (int k = 0; k < 3; k++) slot('0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("uf_flag", underflow, 1);
    check("uf_count3", underflow_count, EXP_UF3);
    slot('0, '0, 1'b0, 1'b1, 1'b0, '0);
    check("uf_clr_flag", underflow, 0);
    check("uf_clr_count", underflow_count, 0);

    // Empty FIFO lets aux win two slots in a row, and no underflow is raised.
    bus.tp_req = 1'b1;
    slot(TP_I, TP_Q, 1'b1, 1'b0, 1'b0, '0);
    slot(TP_I, TP_Q, 1'b1, 1'b0, 1'b0, '0);
    bus.tp_req = 1'b0;
    check("aux_empty_no_uf", underflow, 0);

`ifdef TX_SCHED_UNDERFLOW_CNT_EN
    // Saturation: 65537 consecutive empty slots.
    bus.ser_data_ready = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      sb.push_back(exp_t'(0));
      @(negedge clk);
    end
    bus.ser_data_ready = 1'b0;
    @(negedge clk);
    check("sat_count", underflow_count, 16'hFFFF);
    check("sat_flag", underflow, 1);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("sat_clr_count", underflow_count, 0);
    check("sat_clr_flag", underflow, 0);
`endif

    // Drain: two queued samples, aux requests ignored, third slot zero without underflow.
    push(14'h100);
    push(14'h101);
    check("drain_level2", fifo_level, 2);
    enable     = 1'b0;
    bus.tp_req = 1'b1;
    @(negedge clk);
    check("drain_state", state, 3);
    check("drain_s_ready", bus.s_ready, 0);
    check("drain_ser_oe", bus.ser_oe, 1);
    slot(14'h100, qv(14'h100), 1'b0, 1'b0, 1'b0, '0);
    slot(14'h101, qv(14'h101), 1'b0, 1'b0, 1'b0, '0);
    slot('0, '0, 1'b0, 1'b0, 1'b0, '0);
    bus.tp_req = 1'b0;
    check("drain_idle_state", state, 0);
    check("drain_idle_ser_oe", bus.ser_oe, 0);
    check("drain_no_uf", underflow, 0);

    // Full: nine pushes into eight entries; the ninth is refused.
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) push(14'h200 + 14'(k));
    check("full_level", fifo_level, 8);
    check("full_s_ready", bus.s_ready, 0);
    check("full_state", state, 2);
    slot(14'h200, qv(14'h200), 1'b0, 1'b0, 1'b0, '0);
    check("full_pop_s_ready", bus.s_ready, 1);

    // Simultaneous push/pop keeps the level; the pointers wrap around.
    for (int k = 1; k <= 7; k++)
      slot(14'h200 + 14'(k), qv(14'h200 + 14'(k)), 1'b0, 1'b0, 1'b1, 14'h210 + 14'(k - 1));
    check("pushpop_level", fifo_level, 7);
    slot(14'h210, qv(14'h210), 1'b0, 1'b0, 1'b0, '0);
    slot(14'h211, qv(14'h211), 1'b0, 1'b0, 1'b0, '0);
    check("wrap_level", fifo_level, 5);

    // One-edge reset in the middle of RUN discards everything.
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    enable  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("rearm_state", state, 1);
    check("rearm_level", fifo_level, 0);

    @(negedge clk);
    check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_sample_scheduler.md
# tx_sample_scheduler

Sample scheduler in front of the LVDS I/Q serializer. It buffers the primary DSP sample stream in a small FIFO and primes the FIFO before enabling the serializer. It arbitrates each serializer word slot between the primary stream and an auxiliary (test-pattern/calibration) requester, and it detects and counts underflows. The serializer's word-request strobe paces the block; the block drives the serializer's output-enable and I/Q data inputs.

## Interface
- FIFO_DEPTH, 8: primary FIFO entries; power of two, 4..64
- PRIME_LEVEL, 4: FIFO level required before the serializer is enabled; 1..FIFO_DEPTH
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run request; level-sensitive
- s_valid  in  1  primary sample valid
- s_ready  out  1  primary sample accepted when s_valid & s_ready at posedge
- s_idata, s_qdata  in  14  primary I/Q sample
- tp_req  in  1  auxiliary requester wants a slot; held until granted
- tp_idata, tp_qdata  in  14  auxiliary I/Q sample; must be stable while tp_req is high
- tp_gnt  out  1  one-cycle pulse; the auxiliary sample was consumed this slot
- ser_oe  out  1  serializer output enable
- ser_idata, ser_qdata  out  14  registered word presented to the serializer
- ser_data_ready  in  1  serializer word-slot strobe, one cycle wide
- underflow  out  1  sticky; a RUN slot was served with no data
- underflow_clr  in  1  clears underflow and underflow_count
- underflow_count  out  16  saturating underflow count
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- state  out  2  IDLE=0, PRIME=1, RUN=2, DRAIN=3

## Operation
- **IDLE**
  - ser_oe=0, s_ready=0.
  - FIFO pointers are held at zero.
  - enable=1 → PRIME.
- **PRIME**
  - s_ready = not full.
  - ser_data_ready and tp_req are ignored.
  - At an edge where the registered fifo_level ≥ PRIME_LEVEL → RUN.
  - enable=0 → IDLE, and the FIFO is flushed.
- **RUN**
  - ser_oe=1; s_ready = not full.
  - On each edge with ser_data_ready=1, exactly one source is loaded into ser_idata/ser_qdata:
    1. Auxiliary, if tp_req=1 and the previous slot was not auxiliary (or the FIFO is empty). tp_gnt pulses on the following cycle.
    2. Otherwise FIFO pop, if the FIFO is non-empty.
    3. Otherwise underflow: load 14'h0 into both outputs, set underflow, and increment underflow_count (saturating at 16'hFFFF).
  - enable=0 → DRAIN.
- **DRAIN**
  - ser_oe=1, s_ready=0, tp_req is ignored.
  - Slots are served from the FIFO only.
  - An empty FIFO at a slot loads zeros without counting an underflow and → IDLE.
  - enable returning to 1 → RUN.
- **FIFO rules**
  - Push and pop in the same cycle are both honoured; the level is unchanged.
  - Push is blocked when full. There is no empty bypass: a push into an empty FIFO cannot be popped in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- **Underflow clear**
  - underflow_clr takes priority over a simultaneous underflow event. In that cycle the result is flag=0 and count=0.
- **Output data**
  - ser_idata/ser_qdata hold their value between slots.

## Timing
- Reset values:
  - state=IDLE; ser_oe=0, s_ready=0, tp_gnt=0, underflow=0.
  - underflow_count=0, fifo_level=0, ser_idata=ser_qdata=0.
  - The auxiliary-last flag is 0.
- Reset mid-operation discards FIFO contents on the next edge.
- Push accepted at edge N → fifo_level updates at N+1.
- Slot strobe at edge N:
  - ser_idata/ser_qdata are valid after edge N (one register stage).
  - tp_gnt is high in cycle N+1.
  - fifo_level decrements at N+1.
- ser_oe rises on the edge that enters RUN. It falls on the edge that leaves DRAIN or PRIME for IDLE.
- ser_data_ready outside RUN/DRAIN has no effect.

## Configuration
- TX_SCHED_UNDERFLOW_CNT_EN
  - Defined: 16-bit saturating underflow_count implemented as above.
  - Undefined: underflow_count is tied to 16'h0 and no counter logic is built. The sticky underflow flag and underflow_clr still function.

## Test plan
- **Priming:** PRIME_LEVEL=4, enable=1, push 4 samples (I=1..4) → state=RUN and ser_oe=1 on the edge after level=4; 3 slots output I=1,2,3 in order.
- **Arbitration:** FIFO holds 5 samples, tp_req held high across 4 slots → slot sources are aux, FIFO, aux, FIFO; tp_gnt pulses twice.
- **Underflow:** RUN with empty FIFO and 3 slots → ser_idata=ser_qdata=0, underflow=1, underflow_count=3. underflow_clr coinciding with a 4th underflow slot → count=0, flag=0.
- **Saturation (macro defined):** force 65537 underflow slots → count=16'hFFFF. Macro undefined → count stays 0 while the flag sets.
- **Drain:** FIFO holds 2 samples, enable drops → s_ready=0, 2 slots served, 3rd slot loads zeros with no underflow, then state=IDLE and ser_oe=0.
- **Full/reset:** push 9 samples with FIFO_DEPTH=8 and no slots → s_ready=0 at level 8. reset_n=0 for one edge mid-RUN → all outputs at reset values and fifo_level=0.
